// File: rtl/layer_priority_mux.sv
// -----------------------------------------------------------------------------
// LayerPriorityMux (module layer_priority_mux)
//
// Purpose:
//   N-layer priority compositor for the VGA pixel path. Every clock it picks
//   the lowest-indexed layer whose pixel is requested, enabled, not equal to
//   the transparent colour key and not hidden by the blink timer. The request
//   flag, colour and layer index of that winner are registered together, so
//   the three outputs always describe the same input pixel. The block also
//   owns the frame-based blink timer used by the HUD and game-over text.
//
// Ports:
//   clk            pixel clock
//   resetN         asynchronous, active-low reset
//   startOfFrame   one-cycle pulse per frame, advances the blink timer
//   layerEnable    per-layer visibility mask (1 = visible)
//   blinkMask      per-layer blink mask (1 = hidden while blinkPhase is 0)
//   drawingRequest per-layer pixel request
//   layerRGB       flat colour bus, layer i at [i*RGB_WIDTH +: RGB_WIDTH]
//   outRequest     registered: some layer won this pixel
//   outRGB         registered winning colour (BACKGROUND when nobody won)
//   outLayer       registered winning layer index (0 when nobody won)
//   blinkPhase     current blink phase (1 = blinking layers visible)
// -----------------------------------------------------------------------------
module layer_priority_mux #(
    parameter int                   NUM_LAYERS   = 5,
    parameter int                   RGB_WIDTH    = 8,
    parameter logic [RGB_WIDTH-1:0] TRANSPARENT  = 8'hFF,
    parameter logic [RGB_WIDTH-1:0] BACKGROUND   = 8'h00,
    parameter int                   BLINK_FRAMES = 16,
    localparam int                  LAYER_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            startOfFrame,
    input  logic [NUM_LAYERS-1:0]           layerEnable,
    input  logic [NUM_LAYERS-1:0]           blinkMask,
    input  logic [NUM_LAYERS-1:0]           drawingRequest,
    input  logic [NUM_LAYERS*RGB_WIDTH-1:0] layerRGB,
    output logic                            outRequest,
    output logic [RGB_WIDTH-1:0]            outRGB,
    output logic [LAYER_W-1:0]              outLayer,
    output logic                            blinkPhase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic                  outRequest_q, outRequest_d;
    logic [RGB_WIDTH-1:0]  outRGB_q, outRGB_d;
    logic [LAYER_W-1:0]    outLayer_q, outLayer_d;
    logic                  blinkPhase_q, blinkPhase_d;
    logic [CNT_W-1:0]      blinkCnt_q, blinkCnt_d;
    logic [NUM_LAYERS-1:0] eligible;

    // A layer may compete for the pixel only if it asks for it, is switched
    // on, is not showing the colour key, and is not currently blinked out.
    // The registered blink phase is used, so a phase flip only affects pixels
    // sampled after the edge that flipped it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eligible[i] = drawingRequest[i]
                        & layerEnable[i]
                        & (layerRGB[i*RGB_WIDTH +: RGB_WIDTH] != TRANSPARENT)
                        & ~(blinkMask[i] & ~blinkPhase_q);
        end
    end

    // Fixed-priority pick. Scanning from the highest index down and letting
    // each eligible layer overwrite the result leaves the lowest eligible
    // index as the final winner. When nobody is eligible the defaults give
    // the background pixel with layer index 0.
    always_comb begin
        outRequest_d = 1'b0;
        outRGB_d     = BACKGROUND;
        outLayer_d   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                outRequest_d = 1'b1;
                outRGB_d     = layerRGB[i*RGB_WIDTH +: RGB_WIDTH];
                outLayer_d   = LAYER_W'(i);
            end
        end
    end

    // Blink timer: counts frame pulses and flips the phase every
    // BLINK_FRAMES frames. A startOfFrame held high counts once per cycle.
    always_comb begin
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        if (startOfFrame) begin
            if (blinkCnt_q == CNT_LAST) begin
                blinkCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                blinkCnt_d   = blinkCnt_q + CNT_W'(1);
            end
        end
    end

    // All state shares one register stage. Reset restarts the blink timer
    // with the phase visible and a full period ahead of it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outRequest_q <= 1'b0;
            outRGB_q     <= BACKGROUND;
            outLayer_q   <= '0;
            blinkPhase_q <= 1'b1;
            blinkCnt_q   <= '0;
        end else begin
            outRequest_q <= outRequest_d;
            outRGB_q     <= outRGB_d;
            outLayer_q   <= outLayer_d;
            blinkPhase_q <= blinkPhase_d;
            blinkCnt_q   <= blinkCnt_d;
        end
    end

    assign outRequest = outRequest_q;
    assign outRGB     = outRGB_q;
    assign outLayer   = outLayer_q;
    assign blinkPhase = blinkPhase_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// -----------------------------------------------------------------------------
// Testbench for layer_priority_mux. Two instances share the clock and reset:
//   dutA: NUM_LAYERS=5, RGB_WIDTH=8, TRANSPARENT=8'hFF, BLINK_FRAMES=2
//   dutB: NUM_LAYERS=8, RGB_WIDTH=12, TRANSPARENT=12'hFFF, BLINK_FRAMES=1
// Each scenario task drives directed vectors and checks hand-computed values.
// -----------------------------------------------------------------------------
module tb_layer_priority_mux;

    logic        clk;
    logic        resetN;

    logic        aSof;
    logic [4:0]  aEn, aBlink, aReq;
    logic [39:0] aRGB;
    logic        aOutReq;
    logic [7:0]  aOutRGB;
    logic [2:0]  aOutLayer;
    logic        aPhase;

    logic        bSof;
    logic [7:0]  bEn, bBlink, bReq;
    logic [95:0] bRGB;
    logic        bOutReq;
    logic [11:0] bOutRGB;
    logic [2:0]  bOutLayer;
    logic        bPhase;

    int checks   = 0;
    int failures = 0;

    layer_priority_mux #(
        .NUM_LAYERS  (5),
        .RGB_WIDTH   (8),
        .TRANSPARENT (8'hFF),
        .BACKGROUND  (8'h00),
        .BLINK_FRAMES(2)
    ) dutA (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (aSof),
        .layerEnable   (aEn),
        .blinkMask     (aBlink),
        .drawingRequest(aReq),
        .layerRGB      (aRGB),
        .outRequest    (aOutReq),
        .outRGB        (aOutRGB),
        .outLayer      (aOutLayer),
        .blinkPhase    (aPhase)
    );

    layer_priority_mux #(
        .NUM_LAYERS  (8),
        .RGB_WIDTH   (12),
        .TRANSPARENT (12'hFFF),
        .BACKGROUND  (12'h000),
        .BLINK_FRAMES(1)
    ) dutB (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (bSof),
        .layerEnable   (bEn),
        .blinkMask     (bBlink),
        .drawingRequest(bReq),
        .layerRGB      (bRGB),
        .outRequest    (bOutReq),
        .outRGB        (bOutRGB),
        .outLayer      (bOutLayer),
        .blinkPhase    (bPhase)
    );

    // Free-running pixel clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setA(input int idx, input logic [7:0] v);
        aRGB[idx*8 +: 8] = v;
    endtask

    task automatic setB(input int idx, input logic [11:0] v);
        bRGB[idx*12 +: 12] = v;
    endtask

    // Asynchronous reset state of both instances.
    task automatic test_reset();
        resetN = 1'b1;
        #1 resetN = 1'b0;
        #2;
        checks++; if (aOutReq !== 1'b0) begin failures++; $display("[TB] FAIL reset_req actual=%b expected=0", aOutReq); end
        checks++; if (aOutRGB !== 8'h00) begin failures++; $display("[TB] FAIL reset_rgb actual=%h expected=00", aOutRGB); end
        checks++; if (aOutLayer !== 3'd0) begin failures++; $display("[TB] FAIL reset_layer actual=%0d expected=0", aOutLayer); end
        checks++; if (aPhase !== 1'b1) begin failures++; $display("[TB] FAIL reset_phaseA actual=%b expected=1", aPhase); end
        checks++; if (bPhase !== 1'b1) begin failures++; $display("[TB] FAIL reset_phaseB actual=%b expected=1", bPhase); end
        checks++; if (bOutRGB !== 12'h000) begin failures++; $display("[TB] FAIL reset_rgbB actual=%h expected=000", bOutRGB); end
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    // Lowest eligible index wins; outputs follow one clock later.
    task automatic test_priority();
        aEn = 5'b11111; aBlink = 5'b00000;
        setA(1, 8'h12); setA(3, 8'h34);
        aReq = 5'b01010;
        step();
        checks++; if (aOutReq !== 1'b1) begin failures++; $display("[TB] FAIL prio_req actual=%b expected=1", aOutReq); end
        checks++; if (aOutRGB !== 8'h12) begin failures++; $display("[TB] FAIL prio_rgb13 actual=%h expected=12", aOutRGB); end
        checks++; if (aOutLayer !== 3'd1) begin failures++; $display("[TB] FAIL prio_layer13 actual=%0d expected=1", aOutLayer); end
        aReq = 5'b01000;
        step();
        checks++; if (aOutRGB !== 8'h34) begin failures++; $display("[TB] FAIL prio_rgb3 actual=%h expected=34", aOutRGB); end
        checks++; if (aOutLayer !== 3'd3) begin failures++; $display("[TB] FAIL prio_layer3 actual=%0d expected=3", aOutLayer); end
        setA(0, 8'h01); setA(2, 8'h23); setA(4, 8'h45);
        aReq = 5'b11111;
        step();
        checks++; if (aOutRGB !== 8'h01 || aOutLayer !== 3'd0) begin failures++; $display("[TB] FAIL prio_all actual=%h/%0d expected=01/0", aOutRGB, aOutLayer); end
        aReq = 5'b00000;
        step();
        checks++; if (aOutReq !== 1'b0) begin failures++; $display("[TB] FAIL prio_none actual=%b expected=0", aOutReq); end
    endtask

    // Colour key and enable mask both remove a layer from the contest.
    task automatic test_transparency_enable();
        aEn = 5'b11111;
        setA(0, 8'hFF); setA(2, 8'h56);
        aReq = 5'b00101;
        step();
        checks++; if (aOutRGB !== 8'h56 || aOutLayer !== 3'd2) begin failures++; $display("[TB] FAIL transp actual=%h/%0d expected=56/2", aOutRGB, aOutLayer); end
        aEn = 5'b11011;
        step();
        checks++; if (aOutReq !== 1'b0 || aOutRGB !== 8'h00 || aOutLayer !== 3'd0) begin failures++; $display("[TB] FAIL enable_none actual=%b/%h/%0d expected=0/00/0", aOutReq, aOutRGB, aOutLayer); end
        setA(0, 8'h11); setA(1, 8'h22);
        aEn = 5'b11110; aReq = 5'b00011;
        step();
        checks++; if (aOutRGB !== 8'h22 || aOutLayer !== 3'd1) begin failures++; $display("[TB] FAIL enable_skip0 actual=%h/%0d expected=22/1", aOutRGB, aOutLayer); end
        aEn = 5'b11111; aReq = 5'b00000;
        step();
    endtask

    // A new pixel every cycle with no bubbles.
    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40;
        aReq = 5'b10000;
        setA(4, vals[0]);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (aOutRGB !== vals[k] || aOutLayer !== 3'd4) begin failures++; $display("[TB] FAIL b2b_%0d actual=%h/%0d expected=%h/4", k, aOutRGB, aOutLayer, vals[k]); end
            if (k < 3) setA(4, vals[k+1]);
        end
        aReq = 5'b00000;
        step();
    endtask

    // Blink with BLINK_FRAMES=2, layer 0 blinked and requesting 8'h77.
    task automatic test_blink();
        aBlink = 5'b00001; aEn = 5'b11111;
        setA(0, 8'h77); aReq = 5'b00001;
        step();
        checks++; if (aOutReq !== 1'b1 || aOutRGB !== 8'h77) begin failures++; $display("[TB] FAIL blink_visible actual=%b/%h expected=1/77", aOutReq, aOutRGB); end
        aSof = 1'b1; step(); aSof = 1'b0;
        checks++; if (aPhase !== 1'b1) begin failures++; $display("[TB] FAIL blink_one_pulse actual=%b expected=1", aPhase); end
        aSof = 1'b1; step(); aSof = 1'b0;
        checks++; if (aPhase !== 1'b0) begin failures++; $display("[TB] FAIL blink_phase0 actual=%b expected=0", aPhase); end
        checks++; if (aOutReq !== 1'b1 || aOutRGB !== 8'h77) begin failures++; $display("[TB] FAIL blink_edge_old actual=%b/%h expected=1/77", aOutReq, aOutRGB); end
        step();
        checks++; if (aOutReq !== 1'b0 || aOutRGB !== 8'h00) begin failures++; $display("[TB] FAIL blink_hidden actual=%b/%h expected=0/00", aOutReq, aOutRGB); end
        setA(2, 8'h2A); aReq = 5'b00101;
        step();
        checks++; if (aOutRGB !== 8'h2A || aOutLayer !== 3'd2) begin failures++; $display("[TB] FAIL blink_unmasked actual=%h/%0d expected=2a/2", aOutRGB, aOutLayer); end
        aReq = 5'b00001;
        aSof = 1'b1; step(); aSof = 1'b0;
        aSof = 1'b1; step(); aSof = 1'b0;
        checks++; if (aPhase !== 1'b1 || aOutReq !== 1'b0) begin failures++; $display("[TB] FAIL blink_back_edge actual=%b/%b expected=1/0", aPhase, aOutReq); end
        step();
        checks++; if (aOutReq !== 1'b1 || aOutRGB !== 8'h77) begin failures++; $display("[TB] FAIL blink_reshown actual=%b/%h expected=1/77", aOutReq, aOutRGB); end
    endtask

    // Asynchronous reset in the middle of a blink-off period.
    task automatic test_reset_mid();
        setA(2, 8'h2A); aReq = 5'b00101;
        aSof = 1'b1; step(); aSof = 1'b0;
        aSof = 1'b1; step(); aSof = 1'b0;
        step();
        checks++; if (aPhase !== 1'b0 || aOutReq !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pre actual=%b/%b expected=0/1", aPhase, aOutReq); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (aOutReq !== 1'b0 || aOutRGB !== 8'h00 || aOutLayer !== 3'd0) begin failures++; $display("[TB] FAIL rmid_out actual=%b/%h/%0d expected=0/00/0", aOutReq, aOutRGB, aOutLayer); end
        checks++; if (aPhase !== 1'b1) begin failures++; $display("[TB] FAIL rmid_phase actual=%b expected=1", aPhase); end
        step();
        resetN = 1'b1;
        aReq = 5'b00001;
        aSof = 1'b1; step(); aSof = 1'b0;
        checks++; if (aPhase !== 1'b1 || aOutReq !== 1'b1) begin failures++; $display("[TB] FAIL rmid_full_period actual=%b/%b expected=1/1", aPhase, aOutReq); end
        aReq = 5'b00000;
        step();
    endtask

    // Wider instance: 8 layers, 12-bit colour, blink every frame.
    task automatic test_param();
        bEn = 8'hFF; bBlink = 8'h00;
        setB(5, 12'hABC); setB(7, 12'h123);
        bReq = 8'b1010_0000;
        step();
        checks++; if (bOutRGB !== 12'hABC || bOutLayer !== 3'd5) begin failures++; $display("[TB] FAIL param_prio actual=%h/%0d expected=abc/5", bOutRGB, bOutLayer); end
        setB(5, 12'hFFF);
        step();
        checks++; if (bOutRGB !== 12'h123 || bOutLayer !== 3'd7) begin failures++; $display("[TB] FAIL param_transp actual=%h/%0d expected=123/7", bOutRGB, bOutLayer); end
        bBlink = 8'b0100_0000; setB(6, 12'h456); bReq = 8'b0100_0000;
        step();
        checks++; if (bOutReq !== 1'b1 || bOutRGB !== 12'h456 || bOutLayer !== 3'd6) begin failures++; $display("[TB] FAIL param_blink_vis actual=%b/%h/%0d expected=1/456/6", bOutReq, bOutRGB, bOutLayer); end
        bSof = 1'b1; step(); bSof = 1'b0;
        checks++; if (bPhase !== 1'b0 || bOutReq !== 1'b1) begin failures++; $display("[TB] FAIL param_toggle1 actual=%b/%b expected=0/1", bPhase, bOutReq); end
        step();
        checks++; if (bOutReq !== 1'b0) begin failures++; $display("[TB] FAIL param_hidden actual=%b expected=0", bOutReq); end
        bSof = 1'b1; step(); bSof = 1'b0;
        checks++; if (bPhase !== 1'b1 || bOutReq !== 1'b0) begin failures++; $display("[TB] FAIL param_toggle2 actual=%b/%b expected=1/0", bPhase, bOutReq); end
        step();
        checks++; if (bOutReq !== 1'b1 || bOutRGB !== 12'h456) begin failures++; $display("[TB] FAIL param_reshown actual=%b/%h expected=1/456", bOutReq, bOutRGB); end
    endtask

    initial begin
        aSof = 1'b0; aEn = '0; aBlink = '0; aReq = '0; aRGB = '0;
        bSof = 1'b0; bEn = '0; bBlink = '0; bReq = '0; bRGB = '0;
        test_reset();
        test_priority();
        test_transparency_enable();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
